// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch queue storage: DEPTH-entry FIFO of {pc, inst}; flush beats push/pop.
module ifq_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  ifq_entry_t                 push_data,
  output logic [$clog2(DEPTH):0]     count,
  output ifq_entry_t                 head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ifq_entry_t          mem_q [DEPTH];
  logic [AW-1:0]       rd_ptr_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [CW-1:0]       count_q;

  // Entry storage; a flushed push is simply never written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with prefetch queue feeding decode.
// Optional feature macro IFQ_BYPASS_EN: forwards a zero-wait response straight
// to decode when the queue is empty.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifq_state_t    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  ifq_entry_t    head;
  ifq_entry_t    push_data;
  logic          ack_wait;
  logic          byp;
  logic          deq;
  logic          push;
  logic          pop;
  logic          room;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .count     (count),
    .head      (head)
  );

  assign ack_wait = (state_q == WAIT) && imem_ack;
  assign pc_inc   = fetch_pc_q + 32'd4;

`ifdef IFQ_BYPASS_EN
  assign byp = (count == '0) && ack_wait && !redirect;
`else
  assign byp = 1'b0;
`endif

  // Decode-side view of the queue head (or the bypassed response).
  assign d_valid = !redirect && ((count != '0) || byp);
  assign d_inst  = !d_valid ? NOP_INST : (byp ? imem_rdata : head.inst);
  assign d_pc    = !d_valid ? 32'h0    : (byp ? fetch_pc_q : head.pc);

  // Queue traffic; a consumed bypass entry never touches the FIFO.
  assign deq        = d_valid && d_ready;
  assign push       = ack_wait && !redirect && !(byp && d_ready);
  assign pop        = deq && !byp;
  assign push_data  = '{pc: fetch_pc_q, inst: imem_rdata};
  assign count_next = count + CW'(push) - CW'(pop);
  assign room       = count_next < DEPTH_C;

  // Next-state, fetch PC and request address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end
    case (state_q)
      IDLE: begin
        if (!redirect && room) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_d = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          fetch_pc_d = pc_inc;
          if (room) begin
            addr_d = pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fetch PC and request address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: transaction-level model plus directed scenarios.
module tb_ifetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP   = 1'b1;
  localparam int FIRST = 1;
`else
  localparam bit BYP   = 1'b0;
  localparam int FIRST = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [31:0] d_inst;
  logic [31:0] d_pc;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int wcnt  = 0;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_inst      (d_inst),
    .d_pc        (d_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory latency counter: cycles the current request has waited.
  always @(posedge clk) begin
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // One clock cycle of stimulus; the memory answers after lat waiting cycles.
  task automatic cyc(input logic r, input logic rdy, input logic redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst         = r;
    d_ready     = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    imem_ack    = imem_req && (wcnt >= lat);
    imem_rdata  = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    #2;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- transaction-level model, checked every negedge ----------------
  logic [63:0] mq[$];
  logic [31:0] m_nf, m_cur, m_epc, m_einst;
  bit          m_pending, m_stale, m_exp_req, m_byp, m_ev, m_used, m_blocked;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_nf      = RST_PC;
      m_cur     = RST_PC;
      m_pending = 1'b0;
      m_stale   = 1'b0;
      m_exp_req = 1'b0;
    end else begin
      check("m_req", 32'(imem_req), 32'(m_exp_req));
      if (imem_req) begin
        if (!m_pending) begin
          m_cur   = m_nf;
          m_stale = 1'b0;
        end
        check("m_addr", imem_addr, m_cur);
      end
      m_byp = BYP && (mq.size() == 0) && imem_req && imem_ack && !m_stale && !redirect;
      m_ev  = !redirect && ((mq.size() > 0) || m_byp);
      if (m_ev && mq.size() > 0) begin
        m_epc   = mq[0][63:32];
        m_einst = mq[0][31:0];
      end else if (m_ev) begin
        m_epc   = m_cur;
        m_einst = mem_word(m_cur);
      end else begin
        m_epc   = 32'h0;
        m_einst = 32'h0;
      end
      check("m_valid", 32'(d_valid), 32'(m_ev));
      check("m_pc", d_pc, m_epc);
      check("m_inst", d_inst, m_einst);
      // advance to the next cycle
      m_blocked = redirect || (imem_req && imem_ack && m_stale);
      if (redirect) begin
        mq.delete();
        m_nf = {redirect_pc[31:2], 2'b00};
        if (imem_req) m_stale = 1'b1;
      end else begin
        m_used = m_byp && d_ready;
        if (m_ev && d_ready && !m_used) void'(mq.pop_front());
        if (imem_req && imem_ack && !m_stale) begin
          if (!m_used) mq.push_back({m_cur, mem_word(m_cur)});
          m_nf = m_cur + 32'd4;
        end
      end
      m_pending = imem_req && !imem_ack;
      if (!m_pending) m_stale = 1'b0;
      m_exp_req = m_pending || (!m_blocked && (mq.size() < DEPTH));
    end
  end

  // ---------------- directed scenarios with literal expectations ----------------
  int  nreq;
  int  nval;
  bit  found;
  logic [31:0] pcs [4];

  initial begin
    // A: zero-wait memory, decode always ready
    do_reset();
    lat = 0;
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("A_rst_req", 32'(imem_req), 32'd0);
    check("A_rst_valid", 32'(d_valid), 32'd0);
    check("A_rst_inst", d_inst, 32'h0);
    check("A_rst_pc", d_pc, 32'h0);
    check("A_rst_addr", imem_addr, RST_PC);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check("A_req", 32'(imem_req), 32'd1);
      check("A_addr", imem_addr, 32'(4 * (k - 1)));
      if (k < FIRST) begin
        check("A_valid_early", 32'(d_valid), 32'd0);
      end else begin
        check("A_valid", 32'(d_valid), 32'd1);
        check("A_pc", d_pc, 32'(4 * (k - FIRST)));
      end
    end

    // B: decode stalled fills the queue, then drains in order
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    nreq = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (imem_req) begin
        check("B_addr", imem_addr, 32'(4 * nreq));
        nreq++;
      end
    end
    check("B_nreq", 32'(nreq), 32'd4);
    check("B_full_req", 32'(imem_req), 32'd0);
    check("B_full_valid", 32'(d_valid), 32'd1);
    for (int k = 10; k <= 14; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check("B_pc", d_pc, 32'(4 * (k - 10)));
      if (k == 11) begin
        check("B_resume_req", 32'(imem_req), 32'd1);
        check("B_resume_addr", imem_addr, 32'h10);
      end
    end

    // C: slow memory, redirect while waiting
    do_reset();
    lat = 3;
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    check("C_redir_valid", 32'(d_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("C_hold_req", 32'(imem_req), 32'd1);
    check("C_hold_addr", imem_addr, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("C_ack_addr", imem_addr, 32'h0);
    check("C_drop_valid", 32'(d_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("C_gap_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("C_new_req", 32'(imem_req), 32'd1);
    check("C_new_addr", imem_addr, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (d_valid) found = 1'b1;
      else cyc(1'b0, 1'b1, 1'b0, 32'h0);
    end
    check("C_found", 32'(found), 32'd1);
    check("C_first_pc", d_pc, 32'h40);
    check("C_first_inst", d_inst, mem_word(32'h40));

    // D: redirect coinciding with an ack, two entries queued, unaligned target
    do_reset();
    lat = 0;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h103);
    check("D_redir_valid", 32'(d_valid), 32'd0);
    check("D_redir_inst", d_inst, 32'h0);
    check("D_redir_pc", d_pc, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("D_empty_valid", 32'(d_valid), 32'd0);
    check("D_idle_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("D_new_req", 32'(imem_req), 32'd1);
    check("D_new_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (d_valid) found = 1'b1;
      else cyc(1'b0, 1'b1, 1'b0, 32'h0);
    end
    check("D_found", 32'(found), 32'd1);
    check("D_first_pc", d_pc, 32'h100);

    // F: fetch PC wraps past the top of the address space
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    check("F_redir_valid", 32'(d_valid), 32'd0);
    nval = 0;
    for (int i = 0; i < 20 && nval < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      if (d_valid) begin
        pcs[nval] = d_pc;
        nval++;
      end
    end
    check("F_count", 32'(nval), 32'd4);
    check("F_pc0", pcs[0], 32'hFFFF_FFF8);
    check("F_pc1", pcs[1], 32'hFFFF_FFFC);
    check("F_pc2", pcs[2], 32'h0);
    check("F_pc3", pcs[3], 32'h4);

    // E: reset with a nearly full queue and a request outstanding
    do_reset();
    lat = 0;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    lat = 100;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("E_pend_req", 32'(imem_req), 32'd1);
    check("E_pend_addr", imem_addr, 32'hC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    lat = 0;
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("E_rst_valid", 32'(d_valid), 32'd0);
    check("E_rst_inst", d_inst, 32'h0);
    check("E_rst_pc", d_pc, 32'h0);
    check("E_rst_req", 32'(imem_req), 32'd0);
    check("E_rst_addr", imem_addr, RST_PC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("E_restart_req", 32'(imem_req), 32'd1);
    check("E_restart_addr", imem_addr, RST_PC);

    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch unit with a prefetch queue, directly upstream of the decode stage. It runs a single-outstanding req/ack handshake against instruction memory and buffers returned instructions with their PCs in a small FIFO. It presents them to decode through a valid/ready handshake, and handles taken-branch redirects from the memory stage (pc_src / branch target) by flushing the queue and discarding in-flight responses.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0: first fetch address after reset.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  response strobe; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  instruction; valid only with imem_ack.
- redirect  in  1  taken branch (pc_src); one-cycle pulse.
- redirect_pc  in  32  branch target; sampled when redirect=1.
- d_valid  out  1  head entry available to decode.
- d_ready  in  1  decode accepts the head entry.
- d_inst  out  32  head instruction; 32'h0 (nop) when d_valid=0.
- d_pc  out  32  head PC; 32'h0 when d_valid=0.

## Operation
- States: IDLE (no request), WAIT (imem_req=1), DISCARD (imem_req=1, response is dropped). imem_req = (state != IDLE).
- deq = d_valid & d_ready & ~redirect. count_next = count + enq - deq, where enq = ack in WAIT & ~redirect.
- IDLE: if ~redirect and count_next < DEPTH, go to WAIT with imem_addr <= fetch_pc.
- WAIT, ack: enqueue {fetch_pc, imem_rdata}; fetch_pc += 4. If count_next < DEPTH, stay in WAIT with imem_addr <= new fetch_pc (back-to-back requests). Otherwise go to IDLE.
- WAIT, no ack: hold imem_addr and imem_req.
- An outstanding request always reserves one slot, so an ack never arrives into a full queue.
- Redirect has priority over enqueue, dequeue and issue:
  - Flush the queue (count <= 0) and set fetch_pc <= redirect_pc.
  - d_valid is forced to 0 in the redirect cycle.
  - In WAIT without ack, or in DISCARD without ack: go to DISCARD. The request stays asserted with its old address because a handshake is never abandoned.
  - In WAIT or DISCARD with ack: drop the data and go to IDLE.
  - In IDLE: stay in IDLE.
- DISCARD, ack: drop the data and go to IDLE. The next cycle issues fetch_pc, which holds the redirect target.
- fetch_pc wraps modulo 2^32. Bits [1:0] of redirect_pc are ignored (forced to 0).
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, count=0.
  - imem_req=0, imem_addr=RESET_PC.
  - d_valid=0, d_inst=0, d_pc=0.
- Reset mid-handshake abandons the request; the memory must tolerate a dropped req.

## Timing
- imem_req and imem_addr are registered. d_valid, d_inst and d_pc are driven from the queue head, gated only by redirect (and by bypass when enabled).
- Zero-wait memory (ack=req), queue empty:
  - rst falls before edge 0.
  - imem_req rises after edge 1.
  - d_valid rises after edge 2 with d_pc=RESET_PC.
- Sustained throughput is 1 instruction/cycle when imem_ack=1 and d_ready=1.
- A redirect in cycle N gives a first request at redirect_pc after edge N+1. The exception is DISCARD, where the first request follows the dropped ack by one cycle.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the queue is empty, state=WAIT, imem_ack=1 and ~redirect, drive d_valid=1, d_inst=imem_rdata, d_pc=fetch_pc combinationally.
  - If d_ready, the entry is not enqueued.
  - Result: zero-wait first d_valid appears after edge 1.
- IFQ_BYPASS_EN undefined: every instruction passes through the queue, adding one cycle of latency.

## Structure
- Shared package mips_pkg:
  - NOP_INST = 32'h0.
  - ifq_state_t enum {IDLE, WAIT, DISCARD}.
  - ifq_entry_t struct {pc[31:0], inst[31:0]}.
  - Default RESET_PC.
- Sub-module ifq_fifo: synchronous DEPTH-entry FIFO of ifq_entry_t with push, pop, flush, count, head.
  - flush has priority over push and pop.
  - Pointers wrap modulo DEPTH.
- The FSM and PC logic stay in ifetch_queue.

## Test plan
- Reset; ack=req; d_ready=1 → d_pc sequence 0,4,8,12,… one per cycle; first d_valid after edge 2; imem_addr never skips a word.
- d_ready=0, DEPTH=4 → exactly 4 requests (addr 0,4,8,12); imem_req=0 while full; raising d_ready resumes at addr 16 with order preserved.
- Ack delayed 3 cycles; redirect with redirect_pc=0x40 in the second wait cycle → imem_addr holds the old value until ack; that data never appears at decode; next request is 0x40; first d_pc after the redirect is 0x40.
- Redirect in the same cycle as ack with 2 entries queued → d_valid=0 that cycle; queue empty next cycle; next imem_addr=redirect_pc; no stale PC ever delivered.
- rst asserted with the queue full and a request pending → after the edge: d_valid=0, d_inst=0, imem_req=0; fetching restarts at RESET_PC.
- IFQ_BYPASS_EN defined, empty queue, ack=req, d_ready=1 → d_valid rises after edge 1; count stays 0; d_inst equals imem_rdata in the same cycle.
